// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS datapath.
// Sequences IF/ID/EX/MEM/WB, decodes opcode/funct into alu_op and datapath
// mux selects, and keeps cycle / retired-instruction performance counters.
module multicycle_ctrl #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 alu_zero,
  input  logic                 inst_valid,
  input  logic                 mem_ready,
  output logic                 inst_req,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic [2:0]           alu_op,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 imm_zext,
  output logic                 reg_write,
  output logic                 reg_dst,
  output logic                 mem_to_reg,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] inst_cnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SLTU = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_NOR  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_WIDTH-1:0] inst_cnt_q, inst_cnt_d;

  logic       funct_ok;
  logic [2:0] r_alu_op;
  logic       i_alu;
  logic [2:0] i_alu_op;
  logic       i_zext;
  logic       is_r, is_lw, is_sw, is_beq, is_bne, is_j;
  logic       supported;

  assign is_r   = (opcode == OP_RTYPE);
  assign is_lw  = (opcode == OP_LW);
  assign is_sw  = (opcode == OP_SW);
  assign is_beq = (opcode == OP_BEQ);
  assign is_bne = (opcode == OP_BNE);
  assign is_j   = (opcode == OP_J);

  // R-type funct decode; funct_ok low marks an unknown funct (executed as NOP)
  always_comb begin
    funct_ok = 1'b1;
    r_alu_op = ALU_AND;
    case (funct)
      6'h21:   r_alu_op = ALU_ADD;
      6'h23:   r_alu_op = ALU_SUB;
      6'h24:   r_alu_op = ALU_AND;
      6'h25:   r_alu_op = ALU_OR;
      6'h26:   r_alu_op = ALU_XOR;
      6'h27:   r_alu_op = ALU_NOR;
      6'h2A:   r_alu_op = ALU_SLT;
      6'h2B:   r_alu_op = ALU_SLTU;
      default: funct_ok = 1'b0;
    endcase
  end

  // I-type ALU decode; logical immediates are zero-extended
  always_comb begin
    i_alu    = 1'b1;
    i_alu_op = ALU_AND;
    i_zext   = 1'b0;
    case (opcode)
      6'h09:   i_alu_op = ALU_ADD;
      6'h0A:   i_alu_op = ALU_SLT;
      6'h0B:   i_alu_op = ALU_SLTU;
      6'h0C:   begin i_alu_op = ALU_AND; i_zext = 1'b1; end
      6'h0D:   begin i_alu_op = ALU_OR;  i_zext = 1'b1; end
      6'h0E:   begin i_alu_op = ALU_XOR; i_zext = 1'b1; end
      default: i_alu = 1'b0;
    endcase
  end

  assign supported = (is_r && funct_ok) || i_alu || is_lw || is_sw ||
                     is_beq || is_bne || is_j;

  // State register and performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IF;
      cycle_cnt_q <= '0;
      inst_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      inst_cnt_q  <= inst_cnt_d;
    end
  end

  // Next-state, control outputs and counter updates; reset forces outputs low
  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q + CNT_WIDTH'(1);
    inst_cnt_d  = inst_cnt_q;
    inst_req    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    alu_op      = 3'b000;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    imm_zext    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;

    case (state_q)
      S_IF: begin
        inst_req  = 1'b1;
        alu_op    = ALU_ADD;
        alu_src_b = 2'b01;
        if (inst_valid) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_ID;
        end
      end
      S_ID: begin
        alu_op    = ALU_ADD;
        alu_src_b = 2'b11;
        state_d   = supported ? S_EX : S_IF;
      end
      S_EX: begin
        alu_src_a = 1'b1;
        state_d   = S_IF;
        if (is_r) begin
          alu_op  = r_alu_op;
          state_d = S_WB;
        end else if (i_alu) begin
          alu_op    = i_alu_op;
          alu_src_b = 2'b10;
          imm_zext  = i_zext;
          state_d   = S_WB;
        end else if (is_lw || is_sw) begin
          alu_op    = ALU_ADD;
          alu_src_b = 2'b10;
          state_d   = S_MEM;
        end else if (is_beq || is_bne) begin
          alu_op   = ALU_SUB;
          pc_src   = 2'b01;
          pc_write = is_beq ? alu_zero : ~alu_zero;
        end else if (is_j) begin
          pc_src   = 2'b10;
          pc_write = 1'b1;
        end
      end
      S_MEM: begin
        mem_read  = is_lw;
        mem_write = is_sw;
        if (mem_ready) begin
          state_d = is_lw ? S_WB : S_IF;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_r;
        mem_to_reg = is_lw;
        state_d    = S_IF;
      end
      default: state_d = S_IF;
    endcase

    if ((state_d == S_IF) && (state_q != S_IF)) begin
      inst_cnt_d = inst_cnt_q + CNT_WIDTH'(1);
    end

    if (rst) begin
      inst_req   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      alu_op     = 3'b000;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      imm_zext   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign inst_cnt  = inst_cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus side pushes the expected
// control vector and counter values for every cycle it drives; an independent
// monitor pops and compares them on each falling edge.
module tb_multicycle_ctrl;

  localparam int CW = 32;

  logic          clk;
  logic          rst;
  logic [5:0]    opcode;
  logic [5:0]    funct;
  logic          alu_zero;
  logic          inst_valid;
  logic          mem_ready;
  logic          inst_req;
  logic          ir_write;
  logic          pc_write;
  logic [1:0]    pc_src;
  logic [2:0]    alu_op;
  logic          alu_src_a;
  logic [1:0]    alu_src_b;
  logic          imm_zext;
  logic          reg_write;
  logic          reg_dst;
  logic          mem_to_reg;
  logic          mem_read;
  logic          mem_write;
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] inst_cnt;

  multicycle_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .alu_zero   (alu_zero),
    .inst_valid (inst_valid),
    .mem_ready  (mem_ready),
    .inst_req   (inst_req),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .imm_zext   (imm_zext),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .cycle_cnt  (cycle_cnt),
    .inst_cnt   (inst_cnt)
  );

  typedef struct {
    logic [16:0] ctl;
    logic [31:0] inst;
    logic [31:0] cyc;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cycle = 0;
  logic [31:0] exp_inst = 0;
  logic [16:0] act_ctl;

  // Control vector layout: req irw pcw psrc[2] aop[3] sa sb[2] zx rw rd m2r mr mw
  assign act_ctl = {inst_req, ir_write, pc_write, pc_src, alu_op, alu_src_a,
                    alu_src_b, imm_zext, reg_write, reg_dst, mem_to_reg,
                    mem_read, mem_write};

  function automatic logic [16:0] ctl(
    input logic req, input logic irw, input logic pcw, input logic [1:0] psrc,
    input logic [2:0] aop, input logic sa, input logic [1:0] sb, input logic zx,
    input logic rw, input logic rd, input logic m2r, input logic mr, input logic mw);
    return {req, irw, pcw, psrc, aop, sa, sb, zx, rw, rd, m2r, mr, mw};
  endfunction

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs, records the expected outputs, then advances
  task automatic applyStimulus(input string name, input logic [5:0] op,
                               input logic [5:0] fn, input logic iv,
                               input logic mr, input logic az,
                               input logic [16:0] exp_ctl);
    exp_t e;
    opcode     = op;
    funct      = fn;
    inst_valid = iv;
    mem_ready  = mr;
    alu_zero   = az;
    e.ctl  = exp_ctl;
    e.inst = exp_inst;
    e.cyc  = exp_cycle;
    e.name = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!rst) exp_cycle = exp_cycle + 1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare whatever the stimulus queued for this cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput({e.name, ".ctl"}, 32'(act_ctl), 32'(e.ctl));
      checkOutput({e.name, ".inst_cnt"}, inst_cnt, e.inst);
      checkOutput({e.name, ".cycle_cnt"}, cycle_cnt, e.cyc);
    end
  end

  // Watchdog so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic [16:0] c_if_wait, c_if_go, c_id, c_zero;

  // Fetch (valid on first IF cycle) followed by decode
  task automatic fetchDecode(input string name, input logic [5:0] op,
                             input logic [5:0] fn);
    applyStimulus({name, "_if"}, op, fn, 1'b1, 1'b0, 1'b0, c_if_go);
    applyStimulus({name, "_id"}, op, fn, 1'b0, 1'b0, 1'b0, c_id);
  endtask

  initial begin
    c_if_wait = ctl(1,0,0,2'b00,3'b010,0,2'b01,0,0,0,0,0,0);
    c_if_go   = ctl(1,1,1,2'b00,3'b010,0,2'b01,0,0,0,0,0,0);
    c_id      = ctl(0,0,0,2'b00,3'b010,0,2'b11,0,0,0,0,0,0);
    c_zero    = '0;

    rst = 1'b1; opcode = '0; funct = '0; alu_zero = 1'b0;
    inst_valid = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset held: all controls low, counters zero, even with inputs active
    applyStimulus("reset", 6'h00, 6'h21, 1'b1, 1'b1, 1'b1, c_zero);
    rst = 1'b0;

    // addu
    fetchDecode("addu", 6'h00, 6'h21);
    applyStimulus("addu_ex", 6'h00, 6'h21, 0, 0, 0, ctl(0,0,0,2'b00,3'b010,1,2'b00,0,0,0,0,0,0));
    applyStimulus("addu_wb", 6'h00, 6'h21, 0, 0, 0, ctl(0,0,0,2'b00,3'b000,0,2'b00,0,1,1,0,0,0));
    exp_inst = exp_inst + 1;

    // lw with an IF stall and mem_ready late by 3 cycles
    applyStimulus("lw_if_stall", 6'h23, 6'h00, 0, 0, 0, c_if_wait);
    fetchDecode("lw", 6'h23, 6'h00);
    applyStimulus("lw_ex", 6'h23, 6'h00, 0, 0, 0, ctl(0,0,0,2'b00,3'b010,1,2'b10,0,0,0,0,0,0));
    for (int i = 0; i < 3; i++)
      applyStimulus("lw_mem_wait", 6'h23, 6'h00, 0, 0, 0, ctl(0,0,0,2'b00,3'b000,0,2'b00,0,0,0,0,1,0));
    applyStimulus("lw_mem_done", 6'h23, 6'h00, 0, 1, 0, ctl(0,0,0,2'b00,3'b000,0,2'b00,0,0,0,0,1,0));
    applyStimulus("lw_wb", 6'h23, 6'h00, 0, 0, 0, ctl(0,0,0,2'b00,3'b000,0,2'b00,0,1,0,1,0,0));
    exp_inst = exp_inst + 1;

    // beq taken / not taken, bne with zero clear
    fetchDecode("beq_t", 6'h04, 6'h00);
    applyStimulus("beq_t_ex", 6'h04, 6'h00, 0, 0, 1, ctl(0,0,1,2'b01,3'b110,1,2'b00,0,0,0,0,0,0));
    exp_inst = exp_inst + 1;
    fetchDecode("beq_n", 6'h04, 6'h00);
    applyStimulus("beq_n_ex", 6'h04, 6'h00, 0, 0, 0, ctl(0,0,0,2'b01,3'b110,1,2'b00,0,0,0,0,0,0));
    exp_inst = exp_inst + 1;
    fetchDecode("bne", 6'h05, 6'h00);
    applyStimulus("bne_ex", 6'h05, 6'h00, 0, 0, 0, ctl(0,0,1,2'b01,3'b110,1,2'b00,0,0,0,0,0,0));
    exp_inst = exp_inst + 1;

    // ori and slti
    fetchDecode("ori", 6'h0D, 6'h00);
    applyStimulus("ori_ex", 6'h0D, 6'h00, 0, 0, 0, ctl(0,0,0,2'b00,3'b001,1,2'b10,1,0,0,0,0,0));
    applyStimulus("ori_wb", 6'h0D, 6'h00, 0, 0, 0, ctl(0,0,0,2'b00,3'b000,0,2'b00,0,1,0,0,0,0));
    exp_inst = exp_inst + 1;
    fetchDecode("slti", 6'h0A, 6'h00);
    applyStimulus("slti_ex", 6'h0A, 6'h00, 0, 0, 0, ctl(0,0,0,2'b00,3'b111,1,2'b10,0,0,0,0,0,0));
    applyStimulus("slti_wb", 6'h0A, 6'h00, 0, 0, 0, ctl(0,0,0,2'b00,3'b000,0,2'b00,0,1,0,0,0,0));
    exp_inst = exp_inst + 1;

    // R-type nor and sltu
    fetchDecode("nor", 6'h00, 6'h27);
    applyStimulus("nor_ex", 6'h00, 6'h27, 0, 0, 0, ctl(0,0,0,2'b00,3'b101,1,2'b00,0,0,0,0,0,0));
    applyStimulus("nor_wb", 6'h00, 6'h27, 0, 0, 0, ctl(0,0,0,2'b00,3'b000,0,2'b00,0,1,1,0,0,0));
    exp_inst = exp_inst + 1;
    fetchDecode("sltu", 6'h00, 6'h2B);
    applyStimulus("sltu_ex", 6'h00, 6'h2B, 0, 0, 0, ctl(0,0,0,2'b00,3'b011,1,2'b00,0,0,0,0,0,0));
    applyStimulus("sltu_wb", 6'h00, 6'h2B, 0, 0, 0, ctl(0,0,0,2'b00,3'b000,0,2'b00,0,1,1,0,0,0));
    exp_inst = exp_inst + 1;

    // jump
    fetchDecode("j", 6'h02, 6'h00);
    applyStimulus("j_ex", 6'h02, 6'h00, 0, 0, 0, ctl(0,0,1,2'b10,3'b000,1,2'b00,0,0,0,0,0,0));
    exp_inst = exp_inst + 1;

    // Unsupported opcode and unknown R funct retire as NOPs from ID
    fetchDecode("op3f", 6'h3F, 6'h00);
    exp_inst = exp_inst + 1;
    fetchDecode("badfn", 6'h00, 6'h00);
    exp_inst = exp_inst + 1;
    applyStimulus("after_nop_if", 6'h00, 6'h00, 0, 0, 0, c_if_wait);

    // sw (mem_ready during EX must be ignored), then reset mid-MEM
    fetchDecode("sw", 6'h2B, 6'h00);
    applyStimulus("sw_ex", 6'h2B, 6'h00, 0, 1, 0, ctl(0,0,0,2'b00,3'b010,1,2'b10,0,0,0,0,0,0));
    applyStimulus("sw_mem", 6'h2B, 6'h00, 0, 0, 0, ctl(0,0,0,2'b00,3'b000,0,2'b00,0,0,0,0,0,1));
    rst = 1'b1;
    exp_cycle = 0;
    exp_inst  = 0;
    applyStimulus("sw_mem_rst", 6'h2B, 6'h00, 0, 0, 0, c_zero);
    rst = 1'b0;
    applyStimulus("post_rst_if", 6'h2B, 6'h00, 0, 0, 0, c_if_wait);
    fetchDecode("post_rst_sw", 6'h2B, 6'h00);

    #10;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
